ysyx_23060025_axi_rd_arb: RTL and testbench

YSYX_23060025_AXI_RD_ARB -- requirements
Module: ysyx_23060025_axi_rd_arb

---
 rtl/ysyx_23060025_axi_rd_arb.sv | 184 ++++++++++++++++++
 tb/tb_ysyx_23060025_axi_rd_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_axi_rd_arb.sv
// ysyx_23060025_axi_rd_arb
//   Arbitrates NUM_M AXI read masters onto a single downstream read port.
//   One burst is in flight at a time. A winner is picked in IDLE, and its
//   AR fields are latched and presented in ADDR. Its R beats are then routed
//   back in DATA. R data is broadcast to every master; only valid/last are
//   steered.
//
// Configuration macro: YSYX_23060025_AXI_ARB_RR_EN
//   defined   -> round-robin arbitration. The pointer advances past the
//                owner when its burst completes.
//   undefined -> fixed priority: the lowest index wins. There is no
//                pointer register.
//
// Ports
//   clock, reset           clock; synchronous active-high reset
//   m_ar*                  packed per-master read-address channels (in)
//   m_arready              per-master address accept
//   m_rdata/rvalid/rlast   read data (broadcast) and per-master valid/last
//   s_ar*, s_r*            downstream read port
//   s_device               1 = burst targets CLINT, 0 = SOC
//   grant_o                index of the current owner
//   busy_o                 a burst is in ADDR or DATA
//   len_err_o              the beat in flight disagrees with the latched arlen
module ysyx_23060025_axi_rd_arb #(
  parameter int                  NUM_M      = 2,
  parameter int                  ADDR_LEN   = 32,
  parameter int                  DATA_LEN   = 32,
  parameter logic [ADDR_LEN-1:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [ADDR_LEN-1:0] CLINT_MASK = 32'hffff_0000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_M-1:0]             m_arvalid,
  input  logic [NUM_M*ADDR_LEN-1:0]    m_araddr,
  input  logic [NUM_M*8-1:0]           m_arlen,
  input  logic [NUM_M*3-1:0]           m_arsize,
  output logic [NUM_M-1:0]             m_arready,
  output logic [DATA_LEN-1:0]          m_rdata,
  output logic [NUM_M-1:0]             m_rvalid,
  output logic [NUM_M-1:0]             m_rlast,
  output logic [ADDR_LEN-1:0]          s_araddr,
  output logic                         s_arvalid,
  input  logic                         s_arready,
  output logic [7:0]                   s_arlen,
  output logic [2:0]                   s_arsize,
  input  logic [DATA_LEN-1:0]          s_rdata,
  input  logic                         s_rvalid,
  input  logic                         s_rlast,
  output logic                         s_rready,
  output logic                         s_device,
  output logic [$clog2(NUM_M)-1:0]     grant_o,
  output logic                         busy_o,
  output logic                         len_err_o
);

  localparam int GW = $clog2(NUM_M);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                r_state;
  logic [GW-1:0]         r_grant;
  logic [ADDR_LEN-1:0]   r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic                  r_device;
  logic [7:0]            r_cnt;
`ifdef YSYX_23060025_AXI_ARB_RR_EN
  logic [GW-1:0]         r_ptr;
`endif

  logic                  w_any;
  logic [GW-1:0]         w_win;
  logic [ADDR_LEN-1:0]   w_win_addr;
  logic                  w_addr_ph;
  logic                  w_data_ph;
  logic                  w_beat;

  assign w_any      = |m_arvalid;
  assign w_win_addr = m_araddr[int'(w_win)*ADDR_LEN +: ADDR_LEN];
  assign w_addr_ph  = (r_state == S_ADDR);
  assign w_data_ph  = (r_state == S_DATA);
  // s_rready is high for the whole DATA phase, so a beat is simply s_rvalid there.
  assign w_beat     = w_data_ph & s_rvalid;

  // Winner selection. Only meaningful while w_any is set.
  always_comb begin : p_pick
    logic found;
    int   j;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    w_win = '0;
    j     = 0;
    for (int k = 0; k < NUM_M; k++) begin
`ifdef YSYX_23060025_AXI_ARB_RR_EN
      // Scan upward from the pointer, wrapping modulo NUM_M (NUM_M need not be a power of two).
      j = int'(r_ptr) + k;
      if (j >= NUM_M) j = j - NUM_M;
`else
      j = k;
`endif
      if (!found && m_arvalid[j]) begin
        found = 1'b1;
        w_win = GW'(j);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the latched AR fields are reset too. They are few, and this keeps the outputs clean out of reset.
      r_state  <= S_IDLE;
      r_grant  <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_device <= 1'b0;
      r_cnt    <= '0;
`ifdef YSYX_23060025_AXI_ARB_RR_EN
      r_ptr    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state  <= S_ADDR;
            r_grant  <= w_win;
            r_addr   <= w_win_addr;
            r_len    <= m_arlen[int'(w_win)*8 +: 8];
            r_size   <= m_arsize[int'(w_win)*3 +: 3];
            r_device <= ((w_win_addr & CLINT_MASK) == CLINT_BASE);
            r_cnt    <= '0;
          end
        end
        S_ADDR: begin
          if (s_arready) r_state <= S_DATA;
        end
        S_DATA: begin
          if (s_rvalid) begin
            r_cnt <= r_cnt + 8'd1;
            // Completion follows s_rlast alone; a length mismatch is only reported.
            if (s_rlast) begin
              r_state  <= S_IDLE;
              r_device <= 1'b0;
`ifdef YSYX_23060025_AXI_ARB_RR_EN
              r_ptr    <= (r_grant == GW'(NUM_M - 1)) ? '0 : r_grant + GW'(1);
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-master steering of the handshakes. Everything is forced low in IDLE.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant == GW'(i)) begin
        m_arready[i] = w_addr_ph & s_arready;
        m_rvalid[i]  = w_data_ph & s_rvalid;
        m_rlast[i]   = w_data_ph & s_rlast;
      end
    end
  end

  assign m_rdata   = s_rdata;
  assign s_arvalid = w_addr_ph;
  assign s_araddr  = r_addr;
  assign s_arlen   = r_len;
  assign s_arsize  = r_size;
  assign s_rready  = w_data_ph;
  assign s_device  = r_device;
  assign grant_o   = r_grant;
  assign busy_o    = w_addr_ph | w_data_ph;

  // r_cnt counts the beats already accepted, so it is the 0-based index of the beat in flight.
  // The error is flagged in two cases: a last beat whose index is not arlen, or a non-last beat whose index is arlen.
  assign len_err_o = w_beat & (s_rlast ? (r_cnt != r_len) : (r_cnt == r_len));

endmodule

// File: tb/tb_ysyx_23060025_axi_rd_arb.sv
// Self-checking bench for ysyx_23060025_axi_rd_arb (NUM_M = 4).
// The reference model picks winners from a plain integer pointer. It also
// derives the expected length error of each beat from that beat's index.
module tb_ysyx_23060025_axi_rd_arb;

  localparam int NM = 4;
  localparam int AL = 32;
  localparam int DL = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NM-1:0]     m_arvalid = '0;
  logic [NM*AL-1:0]  m_araddr = '0;
  logic [NM*8-1:0]   m_arlen = '0;
  logic [NM*3-1:0]   m_arsize = '0;
  logic [NM-1:0]     m_arready;
  logic [DL-1:0]     m_rdata;
  logic [NM-1:0]     m_rvalid;
  logic [NM-1:0]     m_rlast;
  logic [AL-1:0]     s_araddr;
  logic              s_arvalid;
  logic              s_arready = 1'b0;
  logic [7:0]        s_arlen;
  logic [2:0]        s_arsize;
  logic [DL-1:0]     s_rdata = '0;
  logic              s_rvalid = 1'b0;
  logic              s_rlast = 1'b0;
  logic              s_rready;
  logic              s_device;
  logic [1:0]        grant_o;
  logic              busy_o;
  logic              len_err_o;

  ysyx_23060025_axi_rd_arb #(.NUM_M(NM), .ADDR_LEN(AL), .DATA_LEN(DL)) dut (
    .clock(clock), .reset(reset),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .s_rlast(s_rlast), .s_rready(s_rready), .s_device(s_device),
    .grant_o(grant_o), .busy_o(busy_o), .len_err_o(len_err_o)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          ptr_m = 0;
  logic [31:0] a_m [NM];
  logic [7:0]  l_m [NM];
  logic [2:0]  z_m [NM];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: under round-robin, the first requester at or after the pointer wins.
  // Otherwise the lowest index wins.
  function automatic int pick(input logic [NM-1:0] req);
    for (int k = 0; k < NM; k++) begin
`ifdef YSYX_23060025_AXI_ARB_RR_EN
      if (req[(ptr_m + k) % NM]) return (ptr_m + k) % NM;
`else
      if (req[k]) return k;
`endif
    end
    return 0;
  endfunction

  function automatic logic [NM-1:0] onehot(input int g);
    logic [NM-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one complete burst. On entry and on exit the DUT is in IDLE, 1 ns after a rising edge.
  task automatic burst(input logic [NM-1:0] req, input int nbeats, input int len,
                       input bit clint, input bit noisy, input int ar_wait);
    int  g;
    bit  exp_err;
    g = pick(req);
    for (int i = 0; i < NM; i++) begin
      a_m[i] = {1'b1, 31'($urandom)};
      l_m[i] = 8'($urandom);
      z_m[i] = 3'($urandom_range(0, 3));
    end
    a_m[g] = clint ? {16'h0200, 16'($urandom)} : {1'b1, 31'($urandom)};
    l_m[g] = 8'(len);
    for (int i = 0; i < NM; i++) begin
      m_araddr[i*AL +: AL] = a_m[i];
      m_arlen[i*8 +: 8]    = l_m[i];
      m_arsize[i*3 +: 3]   = z_m[i];
    end
    m_arvalid = req;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    s_rdata   = $urandom;
    #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_arvalid", s_arvalid, 0);
    chk("idle_rready", s_rready, 0);
    chk("idle_rdata", m_rdata, s_rdata);
    tick();
    // Now in ADDR. Requests may drop or change without affecting the latched burst.
    if (noisy) m_arvalid = NM'($urandom);
    chk("addr_arvalid", s_arvalid, 1);
    chk("addr_araddr", s_araddr, a_m[g]);
    chk("addr_arlen", s_arlen, l_m[g]);
    chk("addr_arsize", s_arsize, z_m[g]);
    chk("addr_grant", grant_o, g);
    chk("addr_device", s_device, clint);
    chk("addr_busy", busy_o, 1);
    for (int w = 0; w < ar_wait; w++) begin
      chk("addr_wait_arready", m_arready, 0);
      tick();
      chk("addr_wait_arvalid", s_arvalid, 1);
    end
    s_arready = 1'b1;
    #1;
    chk("addr_arready", m_arready, onehot(g));
    chk("addr_rready", s_rready, 0);
    tick();
    s_arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (noisy) m_arvalid = NM'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        s_rvalid = 1'b0;
        #1;
        chk("gap_rvalid", m_rvalid, 0);
        chk("gap_rready", s_rready, 1);
        chk("gap_lenerr", len_err_o, 0);
        tick();
      end
      s_rvalid = 1'b1;
      s_rdata  = $urandom;
      s_rlast  = (b == nbeats - 1);
      exp_err  = s_rlast ? (b != len) : (b == len);
      #1;
      chk("data_rvalid", m_rvalid, onehot(g));
      chk("data_rlast", m_rlast, s_rlast ? onehot(g) : '0);
      chk("data_rdata", m_rdata, s_rdata);
      chk("data_lenerr", len_err_o, exp_err);
      chk("data_device", s_device, clint);
      chk("data_grant", grant_o, g);
      chk("data_arvalid", s_arvalid, 0);
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1;
    chk("post_busy", busy_o, 0);
    chk("post_device", s_device, 0);
    chk("post_rvalid", m_rvalid, 0);
    chk("post_lenerr", len_err_o, 0);
`ifdef YSYX_23060025_AXI_ARB_RR_EN
    ptr_m = (g + 1) % NM;
`endif
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_device", s_device, 0);
    chk("rst_arvalid", s_arvalid, 0);
    reset = 1'b0;

    // No requests: stays idle.
    m_arvalid = '0;
    tick();
    chk("noreq_busy", busy_o, 0);
    tick();
    chk("noreq_busy2", busy_o, 0);

    // Basic 4-beat burst from master 0.
    burst(4'b0001, 4, 3, 1'b0, 1'b0, 0);
    // Three back-to-back single-beat bursts with two requesters.
    burst(4'b0011, 1, 0, 1'b0, 1'b0, 0);
    burst(4'b0011, 1, 0, 1'b0, 1'b0, 0);
    burst(4'b0011, 1, 0, 1'b0, 1'b0, 0);
    // CLINT-targeted burst.
    burst(4'b0010, 2, 1, 1'b1, 1'b0, 1);
    // Early s_rlast: length error on the 2nd beat.
    burst(4'b0001, 2, 3, 1'b0, 1'b0, 0);
    // Late s_rlast: the beat at index arlen is not last, and the real last is at the wrong index.
    burst(4'b0100, 4, 1, 1'b0, 1'b0, 0);
    // Drive the pointer to 3, then test the wraparound and the pointer advance.
    burst(4'b0100, 1, 0, 1'b0, 1'b0, 0);
    burst(4'b0101, 1, 0, 1'b0, 1'b0, 0);
    burst(4'b0111, 1, 0, 1'b0, 1'b0, 0);
    // Requests drop or change after grant.
    burst(4'b1000, 3, 2, 1'b0, 1'b1, 2);

    // Reset in DATA after one beat.
    m_arvalid = 4'b0010;
    for (int i = 0; i < NM; i++) m_arlen[i*8 +: 8] = 8'd3;
    tick();
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    m_arvalid = '0;
    s_rvalid = 1'b1;
    s_rlast  = 1'b0;
    #1;
    chk("rstmid_rvalid_pre", m_rvalid, 4'b0010);
    tick();
    reset = 1'b1;
    tick();
    chk("rstmid_rvalid", m_rvalid, 0);
    chk("rstmid_grant", grant_o, 0);
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_rready", s_rready, 0);
    reset    = 1'b0;
    s_rvalid = 1'b0;
    ptr_m    = 0;
    burst(4'b0011, 1, 0, 1'b0, 1'b0, 0);

    // Randomized bursts.
    for (int n = 0; n < 40; n++) begin
      int nb;
      int ln;
      logic [NM-1:0] rq;
      rq = NM'($urandom_range(1, 15));
      nb = $urandom_range(1, 4);
      ln = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : nb - 1;
      burst(rq, nb, ln, 1'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
